systolic_ctrl: RTL

//  Sequencer for the weight-stationary systolic_array. Loads one weight tile through write_weight_en/in_up_weight,

---
 rtl/systolic_ctrl_pkg.sv | 21 ++
 rtl/systolic_ctrl_skew_line.sv | 20 ++
 rtl/systolic_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/systolic_ctrl_pkg.sv
// systolic_ctrl_pkg: default array geometry, latency and sequencer state encoding for systolic_ctrl.
`ifndef DATASIZE
`define DATASIZE 8
`endif
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef ARRAYHEIGHT
`define ARRAYHEIGHT 4
`endif
`ifndef LAT
`define LAT (`ARRAYHEIGHT + `ARRAYWIDTH)
`endif
package systolic_ctrl_pkg;
  localparam int DEF_DATASIZE    = `DATASIZE;
  localparam int DEF_ARRAYWIDTH  = `ARRAYWIDTH;
  localparam int DEF_ARRAYHEIGHT = `ARRAYHEIGHT;
  localparam int DEF_NVEC_W      = 16;
  localparam int DEF_LAT         = `LAT;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;
endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// skew_line: zero-reset delay line of DEPTH (>=1) registers, used for act skew, output deskew and tokens.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [DEPTH-1:0][WIDTH-1:0] sr_q;
  always_ff @(posedge clk) begin
    if (!rst) sr_q <= '0;
    else begin
      sr_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
    end
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: weight-load, skewed activation streaming and result deskew for a weight-stationary array.
// Optional SYSTOLIC_CTRL_PERF_EN adds perf_cycles/perf_stall counters.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int DATASIZE    = DEF_DATASIZE,
  parameter int ARRAYWIDTH  = DEF_ARRAYWIDTH,
  parameter int ARRAYHEIGHT = DEF_ARRAYHEIGHT,
  parameter int NVEC_W      = DEF_NVEC_W
)(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NVEC_W-1:0]               cfg_n_vec,
  input  logic                            cfg_keep_w,
  output logic                            busy,
  output logic                            done,
  input  logic                            w_valid,
  input  logic [DATASIZE*ARRAYWIDTH-1:0]  w_data,
  output logic                            w_ready,
  input  logic                            a_valid,
  input  logic [DATASIZE*ARRAYHEIGHT-1:0] a_data,
  output logic                            a_ready,
  output logic                            sa_write_weight_en,
  output logic [DATASIZE*ARRAYWIDTH-1:0]  sa_in_up_weight,
  output logic [DATASIZE*ARRAYHEIGHT-1:0] sa_in_left_act,
  input  logic [2*DATASIZE*ARRAYWIDTH-1:0] sa_out_sum,
  output logic                            res_valid,
  output logic [2*DATASIZE*ARRAYWIDTH-1:0] res_data
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]                     perf_cycles,
  output logic [31:0]                     perf_stall
`endif
);
  localparam int LAT = ARRAYHEIGHT + ARRAYWIDTH;
  localparam int SW  = 2 * DATASIZE;
  localparam int CW  = $clog2(LAT + 1);
  state_e state_q, state_d;
  logic [NVEC_W-1:0] n_vec_q, n_vec_d, cnt_q, cnt_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic busy_q, done_q, w_ready_q, a_ready_q, res_valid_q, tok;
  logic [SW*ARRAYWIDTH-1:0] desk, res_data_q;
  logic w_beat, a_acc;
  assign w_beat = w_valid & w_ready_q;
  assign a_acc  = a_valid & a_ready_q;
  always_comb begin
    state_d = state_q;
    n_vec_d = n_vec_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: if (start) begin
        n_vec_d = cfg_n_vec;
        cnt_d   = '0;
        tmr_d   = '0;
        state_d = !cfg_keep_w ? LOAD_W : (cfg_n_vec == '0) ? DONE : STREAM;
      end
      LOAD_W: if (w_beat) begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == CW'(ARRAYHEIGHT - 1)) state_d = (n_vec_q == '0) ? DONE : STREAM;
      end
      STREAM: if (a_acc) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == n_vec_q - 1'b1) begin
          state_d = DRAIN;
          tmr_d   = '0;
        end
      end
      // one extra cycle so done follows the last result rather than coinciding with it
      DRAIN: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == CW'(LAT)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      n_vec_q   <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_vec_q   <= n_vec_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      busy_q    <= state_d != IDLE;
      done_q    <= state_d == DONE;
      w_ready_q <= state_d == LOAD_W;
      a_ready_q <= state_d == STREAM;
    end
  end
  for (genvar i = 0; i < ARRAYHEIGHT; i++) begin : g_skew
    skew_line #(.DEPTH(i + 1), .WIDTH(DATASIZE)) u_skew (
      .clk (clk),
      .rst (rst),
      .d_i (a_acc ? a_data[DATASIZE*i +: DATASIZE] : '0),
      .q_o (sa_in_left_act[DATASIZE*i +: DATASIZE])
    );
  end
  for (genvar j = 0; j < ARRAYWIDTH; j++) begin : g_desk
    if (j < ARRAYWIDTH - 1) begin : g_dly
      skew_line #(.DEPTH(ARRAYWIDTH - 1 - j), .WIDTH(SW)) u_desk (
        .clk (clk),
        .rst (rst),
        .d_i (sa_out_sum[SW*j +: SW]),
        .q_o (desk[SW*j +: SW])
      );
    end else begin : g_thru
      assign desk[SW*j +: SW] = sa_out_sum[SW*j +: SW];
    end
  end
  skew_line #(.DEPTH(LAT), .WIDTH(1)) u_tok (
    .clk (clk),
    .rst (rst),
    .d_i (a_acc),
    .q_o (tok)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= tok;
      res_data_q  <= desk;
    end
  end
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_stall_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (state_q == IDLE && start) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy_q && !(&perf_cycles_q)) perf_cycles_q <= perf_cycles_q + 1'b1;
      if (state_q == STREAM && !a_valid && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end
  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif
  assign busy               = busy_q;
  assign done               = done_q;
  assign w_ready            = w_ready_q;
  assign a_ready            = a_ready_q;
  assign sa_write_weight_en = w_beat;
  assign sa_in_up_weight    = w_ready_q ? w_data : '0;
  assign res_valid          = res_valid_q;
  assign res_data           = res_data_q;
endmodule
